q_train_sequencer: RTL and testbench

Top-level Q-learning training sequencer that drives the policy generator datapath. Per step it:
- fetches the Q-value row for the current state from the Q-table,
- presents the row and the current epsilon to the policy generator,
- issues the chosen action to the environment,
- forwards the transition (s, a, s', r) to the Q-update unit.

It counts steps and episodes, decays epsilon once per episode, and reports training completion.

---
 rtl/q_train_sequencer.sv | 133 +++++++++++++
 tb/tb_q_train_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/q_train_sequencer.sv
// q_train_sequencer: Q-learning training sequencer; fetches Q rows, issues actions,
// forwards transitions to the Q-update unit and decays epsilon per episode.
module q_train_sequencer #(
  parameter int          STATE_W      = 4,
  parameter int          MAX_STEPS    = 64,
  parameter int          NUM_EPISODES = 100,
  parameter logic [15:0] EPS_INIT     = 16'hFFFF,
  parameter logic [15:0] EPS_DECAY    = 16'd512,
  parameter logic [15:0] EPS_MIN      = 16'd1024,
  parameter int          START_STATE  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               q_rd_en,
  output logic [STATE_W-1:0] q_rd_addr,
  input  logic [63:0]        q_values,
  output logic [63:0]        pg_q_values,
  output logic [15:0]        epsilon,
  input  logic [3:0]         pg_action,
  output logic               env_valid,
  input  logic               env_ready,
  output logic [STATE_W-1:0] env_state,
  output logic [3:0]         env_action,
  input  logic               env_resp_valid,
  input  logic [STATE_W-1:0] env_next_state,
  input  logic [15:0]        env_reward,
  input  logic               env_done,
  output logic               upd_valid,
  input  logic               upd_ready,
  output logic [STATE_W-1:0] upd_state,
  output logic [3:0]         upd_action,
  output logic [STATE_W-1:0] upd_next_state,
  output logic [15:0]        upd_reward,
  output logic [7:0]         step_cnt,
  output logic [15:0]        episode_cnt,
  output logic               busy,
  output logic               train_done
);
  typedef enum logic [3:0] {IDLE, FETCH, LATCH, SEL1, SEL2, ACT, WAIT_ENV, UPDATE, NEXT, DONE} state_t;
  localparam logic [16:0]        EPS_FLOOR = {1'b0, EPS_MIN} + {1'b0, EPS_DECAY};
  localparam logic [STATE_W-1:0] START     = STATE_W'(START_STATE);
  state_t             state, state_nxt;
  logic [STATE_W-1:0] cur_state;
  logic               upd_done;
  logic               ep_end;
  logic [15:0]        ep_inc;
  logic [15:0]        eps_dec;
  logic               idle_like;
  assign idle_like  = state == IDLE || state == DONE;
  assign ep_inc     = episode_cnt + 16'd1;
  assign ep_end     = upd_done || step_cnt == 8'(MAX_STEPS);
  // 17-bit compare so the floor test cannot wrap near zero
  assign eps_dec    = ({1'b0, epsilon} < EPS_FLOOR) ? EPS_MIN : epsilon - EPS_DECAY;
  assign q_rd_en    = state == FETCH;
  assign q_rd_addr  = cur_state;
  assign busy       = !idle_like;
  assign train_done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? FETCH : state;
      FETCH:      state_nxt = LATCH;
      LATCH:      state_nxt = SEL1;
      SEL1:       state_nxt = SEL2;
      SEL2:       state_nxt = ACT;
      ACT:        state_nxt = (env_valid && env_ready) ? WAIT_ENV : ACT;
      WAIT_ENV:   state_nxt = env_resp_valid ? UPDATE : WAIT_ENV;
      UPDATE:     state_nxt = (upd_valid && upd_ready) ? NEXT : UPDATE;
      NEXT:       state_nxt = (ep_end && ep_inc == 16'(NUM_EPISODES)) ? DONE : FETCH;
      default:    state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_q_values    <= '0;
      epsilon        <= EPS_INIT;
      env_valid      <= 1'b0;
      env_state      <= '0;
      env_action     <= '0;
      upd_valid      <= 1'b0;
      upd_state      <= '0;
      upd_action     <= '0;
      upd_next_state <= '0;
      upd_reward     <= '0;
      upd_done       <= 1'b0;
      step_cnt       <= '0;
      episode_cnt    <= '0;
      cur_state      <= START;
    end else if (abort) begin
      env_valid <= 1'b0;
      upd_valid <= 1'b0;
    end else begin
      if (idle_like && start) begin
        epsilon     <= EPS_INIT;
        episode_cnt <= '0;
        step_cnt    <= '0;
        cur_state   <= START;
      end
      if (state == LATCH) pg_q_values <= q_values;
      if (state == SEL2) begin
        env_action <= pg_action;
        env_state  <= cur_state;
        env_valid  <= 1'b1;
      end
      if (state == ACT && env_ready) env_valid <= 1'b0;
      if (state == WAIT_ENV && env_resp_valid) begin
        upd_state      <= cur_state;
        upd_action     <= env_action;
        upd_next_state <= env_next_state;
        upd_reward     <= env_reward;
        upd_done       <= env_done;
        upd_valid      <= 1'b1;
      end
      if (state == UPDATE && upd_ready) begin
        upd_valid <= 1'b0;
        cur_state <= upd_next_state;
        step_cnt  <= step_cnt + 8'd1;
      end
      if (state == NEXT && ep_end) begin
        episode_cnt <= ep_inc;
        step_cnt    <= '0;
        cur_state   <= START;
        epsilon     <= eps_dec;
      end
    end
  end
endmodule

// File: tb/tb_q_train_sequencer.sv
// tb_q_train_sequencer: directed table-driven bench for q_train_sequencer with a
// registered policy-generator model and a one-cycle-latency Q-table model.
module tb_q_train_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic        q_rd_en;
  logic [3:0]  q_rd_addr;
  logic [63:0] q_values, pg_q_values, cur_qv = '0;
  logic [15:0] epsilon;
  logic [3:0]  pg_action;
  logic        env_valid, env_ready = 1'b0;
  logic [3:0]  env_state, env_action;
  logic        env_resp_valid = 1'b0, env_done = 1'b0;
  logic [3:0]  env_next_state = '0;
  logic [15:0] env_reward = '0;
  logic        upd_valid, upd_ready = 1'b1;
  logic [3:0]  upd_state, upd_action, upd_next_state;
  logic [15:0] upd_reward;
  logic [7:0]  step_cnt;
  logic [15:0] episode_cnt;
  logic        busy, train_done;
  int errors = 0, checks = 0;
  q_train_sequencer #(
    .STATE_W(4), .MAX_STEPS(3), .NUM_EPISODES(4), .EPS_INIT(16'd1500),
    .EPS_DECAY(16'd512), .EPS_MIN(16'd1024), .START_STATE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_values(q_values),
    .pg_q_values(pg_q_values), .epsilon(epsilon), .pg_action(pg_action),
    .env_valid(env_valid), .env_ready(env_ready), .env_state(env_state),
    .env_action(env_action), .env_resp_valid(env_resp_valid),
    .env_next_state(env_next_state), .env_reward(env_reward), .env_done(env_done),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_state(upd_state),
    .upd_action(upd_action), .upd_next_state(upd_next_state), .upd_reward(upd_reward),
    .step_cnt(step_cnt), .episode_cnt(episode_cnt), .busy(busy), .train_done(train_done)
  );
  always #5 clk = ~clk;
  // Q-table row is only meaningful the cycle after a read strobe
  always @(posedge clk) q_values <= q_rd_en ? cur_qv : 64'hDEAD_BEEF_DEAD_BEEF;
  always @(posedge clk) pg_action <= pg_q_values[19:16];
  typedef struct {
    logic [63:0] qv;
    int          rdy_dly;
    logic [3:0]  cur, act, ns;
    logic [15:0] rw;
    logic        dn;
    logic [7:0]  step;
    logic [15:0] ep, eps;
    logic        fin;
  } vec_t;
  vec_t v[8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_step(input vec_t x);
    int n = 0;
    while (!q_rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_seen", q_rd_en, 1);
    chk("q_rd_addr", q_rd_addr, x.cur);
    cur_qv = x.qv;
    env_ready = (x.rdy_dly == 0);
    repeat (3) @(negedge clk);
    chk("env_valid_early", env_valid, 0);
    @(negedge clk);
    chk("env_req", {env_valid, env_action, env_state}, {1'b1, x.act, x.cur});
    for (int j = 0; j < x.rdy_dly; j++) begin
      @(negedge clk);
      chk("env_hold", {env_valid, env_action, env_state}, {1'b1, x.act, x.cur});
    end
    env_ready = 1'b1;
    @(negedge clk);
    chk("env_single_hs", env_valid, 0);
    env_resp_valid = 1'b1;
    env_next_state = x.ns;
    env_reward = x.rw;
    env_done = x.dn;
    @(negedge clk);
    env_resp_valid = 1'b0;
    env_done = 1'b0;
    chk("upd_fields", {upd_valid, upd_state, upd_action, upd_next_state, upd_reward},
        {1'b1, x.cur, x.act, x.ns, x.rw});
    @(negedge clk);
    chk("upd_cleared", upd_valid, 0);
    @(negedge clk);
    chk("step_cnt", step_cnt, x.step);
    chk("episode_cnt", episode_cnt, x.ep);
    chk("epsilon", epsilon, x.eps);
    chk("done_busy", {train_done, busy}, {x.fin, !x.fin});
  endtask
  initial begin
    vec_t w;
    v[0] = '{64'h0004_0003_0002_0001, 5, 4'd0,  4'd2,  4'd5,  16'hFFF6, 1'b1, 8'd0, 16'd1, 16'd1024, 1'b0};
    v[1] = '{64'h1111_2222_0007_3333, 0, 4'd0,  4'd7,  4'd3,  16'h0064, 1'b1, 8'd0, 16'd2, 16'd1024, 1'b0};
    v[2] = '{64'h0000_0000_0009_0000, 0, 4'd0,  4'd9,  4'd6,  16'h0001, 1'b0, 8'd1, 16'd2, 16'd1024, 1'b0};
    v[3] = '{64'hFFFF_FFFF_000A_FFFF, 2, 4'd6,  4'hA,  4'd9,  16'h8000, 1'b0, 8'd2, 16'd2, 16'd1024, 1'b0};
    v[4] = '{64'h0000_0000_123B_0000, 0, 4'd9,  4'hB,  4'd2,  16'h7FFF, 1'b0, 8'd0, 16'd3, 16'd1024, 1'b0};
    v[5] = '{64'h0000_0000_0001_0000, 0, 4'd0,  4'd1,  4'd4,  16'h0000, 1'b0, 8'd1, 16'd3, 16'd1024, 1'b0};
    v[6] = '{64'h0000_0000_000F_0000, 1, 4'd4,  4'hF,  4'd15, 16'h0005, 1'b0, 8'd2, 16'd3, 16'd1024, 1'b0};
    v[7] = '{64'h0000_0000_0003_0000, 0, 4'd15, 4'd3,  4'd1,  16'hFFFF, 1'b0, 8'd0, 16'd4, 16'd1024, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_outputs", {busy, train_done, env_valid, upd_valid, q_rd_en}, 5'b0);
    chk("rst_regs", {epsilon, episode_cnt, step_cnt, pg_q_values}, {16'd1500, 16'd0, 8'd0, 64'd0});
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cur_qv = '0;
    env_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_act", env_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_act", {env_valid, busy, epsilon}, {1'b0, 1'b0, 16'd1500});
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) run_step(v[i]);
    repeat (3) @(negedge clk);
    chk("done_hold", {train_done, busy, episode_cnt, epsilon}, {1'b1, 1'b0, 16'd4, 16'd1024});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_init", {q_rd_en, epsilon, episode_cnt, step_cnt}, {1'b1, 16'd1500, 16'd0, 8'd0});
    w = '{64'h0000_0000_0005_0000, 0, 4'd0, 4'd5, 4'd7, 16'h0010, 1'b1, 8'd0, 16'd1, 16'd1024, 1'b0};
    run_step(w);
    cur_qv = 64'h0000_0000_0008_0000;
    env_ready = 1'b1;
    upd_ready = 1'b0;
    repeat (5) @(negedge clk);
    env_resp_valid = 1'b1;
    env_next_state = 4'd3;
    env_reward = 16'd1;
    @(negedge clk);
    env_resp_valid = 1'b0;
    chk("upd_wait", upd_valid, 1);
    @(negedge clk);
    chk("upd_hold", {upd_valid, upd_action, upd_next_state}, {1'b1, 4'd8, 4'd3});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_clear", {upd_valid, env_valid, q_rd_en, busy}, 4'b0);
    chk("abort_hold", {episode_cnt, epsilon, step_cnt, pg_q_values},
        {16'd1, 16'd1024, 8'd0, 64'h0000_0000_0008_0000});
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", {busy, q_rd_en}, 2'b00);
    upd_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_after_abort", {q_rd_en, q_rd_addr, epsilon, episode_cnt, step_cnt},
        {1'b1, 4'd0, 16'd1500, 16'd0, 8'd0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
